// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, sends start/8 data bits/odd parity/stop on device clock
// falling edges, samples the device acknowledge and reports the outcome.
// A watchdog aborts any transfer that does not finish in TIMEOUT_CYC cycles.
module ps2_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RTS   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_ACK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Odd parity bit: set when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  state_t               r_state;
  logic [FILT_LEN-1:0]  r_filt;
  logic                 r_fclk;
  logic [8:0]           r_shift;
  logic [INH_W-1:0]     r_inh;
  logic [3:0]           r_bit;
  logic [WD_W-1:0]      r_wdog;
  logic                 r_ack_ok;
  logic                 r_ack_seen;
  logic                 r_c_oe;
  logic                 r_d_oe;
  logic                 r_done;
  logic                 r_err;
  logic                 r_idle;

  logic                 w_fclk_next;
  logic                 w_fall_tick;

  // Glitch filter decision: change level only on a unanimous sample window.
  always_comb begin
    w_fclk_next = r_fclk;
    if (&r_filt) begin
      w_fclk_next = 1'b1;
    end else if (~|r_filt) begin
      w_fclk_next = 1'b0;
    end else begin
      w_fclk_next = r_fclk;
    end
    w_fall_tick = r_fclk & ~w_fclk_next;
  end

  // Glitch filter shift register and filtered clock level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_filt <= '1;
      r_fclk <= 1'b1;
    end else begin
      r_filt <= {ps2c_in, r_filt[FILT_LEN-1:1]};
      r_fclk <= w_fclk_next;
    end
  end

  // Transfer FSM with registered pad enables and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= 9'd0;
      r_inh      <= '0;
      r_bit      <= 4'd0;
      r_wdog     <= '0;
      r_ack_ok   <= 1'b0;
      r_ack_seen <= 1'b0;
      r_c_oe     <= 1'b0;
      r_d_oe     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_ps2) begin
            r_shift    <= {odd_parity(din), din};
            r_inh      <= INH_W'(INHIBIT_CYC - 1);
            r_wdog     <= '0;
            r_ack_seen <= 1'b0;
            r_c_oe     <= 1'b1;
            r_d_oe     <= 1'b0;
            r_idle     <= 1'b0;
            r_state    <= S_RTS;
          end
        end
        S_DONE: begin
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
            // Watchdog expired: free the bus and report a failed transfer.
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
            case (r_state)
              S_RTS: begin
                if (r_inh == '0) begin
                  r_c_oe  <= 1'b0;
                  r_d_oe  <= 1'b1;
                  r_state <= S_START;
                end else begin
                  r_inh <= r_inh - INH_W'(1);
                end
              end
              S_START: begin
                if (w_fall_tick) begin
                  r_bit   <= 4'd8;
                  r_d_oe  <= ~r_shift[0];
                  r_state <= S_DATA;
                end
              end
              S_DATA: begin
                if (w_fall_tick) begin
                  r_shift <= {1'b0, r_shift[8:1]};
                  if (r_bit == 4'd0) begin
                    r_d_oe  <= 1'b0;
                    r_state <= S_STOP;
                  end else begin
                    r_bit  <= r_bit - 4'd1;
                    r_d_oe <= ~r_shift[1];
                  end
                end
              end
              S_STOP: begin
                if (w_fall_tick) begin
                  r_state <= S_ACK;
                end
              end
              S_ACK: begin
                if (w_fall_tick) begin
                  r_ack_ok   <= ~ps2d_in;
                  r_ack_seen <= 1'b1;
                end else if (r_ack_seen && r_fclk) begin
                  r_done  <= 1'b1;
                  r_err   <= ~r_ack_ok;
                  r_state <= S_DONE;
                end
              end
              default: begin
                r_c_oe  <= 1'b0;
                r_d_oe  <= 1'b0;
                r_state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign ps2c_oe      = r_c_oe;
  assign ps2d_oe      = r_d_oe;
  assign tx_idle      = r_idle;
  assign tx_done_tick = r_done;
  assign tx_err       = r_err;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a behavioural PS/2 device drives the clock,
// samples the frame bits, optionally acknowledges, and may inject glitches.
module tb_ps2_tx;

  localparam int INH  = 40;
  localparam int TMO  = 3000;
  localparam int FL   = 8;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe;
  logic       tx_idle, tx_done_tick, tx_err;
  logic       dev_c, dev_d;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  assign ps2c_in = ~(ps2c_oe | dev_c);
  assign ps2d_in = ~(ps2d_oe | dev_d);

  always #5 clk = ~clk;

  ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT_LEN(FL)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always @(negedge clk) begin
    if (tx_done_tick) n_done <= n_done + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference frame: data LSB first, then a parity bit making the ones count odd.
  function automatic logic [8:0] model_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return {((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    check("idle_low_after_wr", {31'd0, tx_idle}, 32'd0);
  endtask

  // Device: measure inhibit, check start bit, clock npulses, sample bits on rising edges.
  task automatic device(input int npulses, input bit do_ack, input bit glitch,
                        output logic [8:0] bits, output logic stop_b,
                        output int inh, output logic start_b);
    int t;
    bits = 9'd0; stop_b = 1'b0; start_b = 1'b1; inh = 0; t = 0;
    while (!ps2c_oe && t < 200) begin @(negedge clk); t++; end
    while (ps2c_oe && inh < 100000) begin inh++; @(negedge clk); end
    start_b = ps2d_in;
    repeat (30) @(negedge clk);
    for (int p = 1; p <= npulses; p++) begin
      dev_c = 1'b1;
      repeat (HALF) @(negedge clk);
      if (p <= 9) bits[p-1] = ps2d_in;
      else if (p == 10) stop_b = ps2d_in;
      dev_c = 1'b0;
      if (p == 11) dev_d = do_ack;
      if (p == 12) dev_d = 1'b0;
      if (p < npulses) begin
        if (glitch && p >= 2 && p <= 8) begin
          repeat (10) @(negedge clk);
          dev_c = 1'b1;
          repeat (3) @(negedge clk);
          dev_c = 1'b0;
          repeat (HALF - 13) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
    end
    dev_c = 1'b0;
    dev_d = 1'b0;
  endtask

  task automatic wait_done(input string name, output bit got);
    int t;
    t = 0;
    while (!tx_done_tick && t < 300) begin @(negedge clk); t++; end
    got = tx_done_tick;
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic finish_xfer(input string name, input int nd0, input logic exp_err);
    bit got;
    wait_done(name, got);
    if (got) check({name, "_err"}, {31'd0, tx_err}, {31'd0, exp_err});
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'd0, tx_done_tick}, 32'd0);
    check({name, "_idle_back"}, {31'd0, tx_idle}, 32'd1);
    @(negedge clk);
    check({name, "_done_count"}, n_done - nd0, 32'd1);
  endtask

  task automatic run_xfer(input string name, input logic [7:0] d, input bit do_ack,
                          input bit glitch, input logic exp_err);
    logic [8:0] bits;
    logic stop_b, start_b;
    int inh, nd0;
    nd0 = n_done;
    send(d);
    device(12, do_ack, glitch, bits, stop_b, inh, start_b);
    check({name, "_inhibit"}, inh, INH);
    check({name, "_start"}, {31'd0, start_b}, 32'd0);
    check({name, "_frame"}, {23'd0, bits}, {23'd0, model_frame(d)});
    check({name, "_stop"}, {31'd0, stop_b}, 32'd1);
    finish_xfer(name, nd0, exp_err);
  endtask

  typedef struct {
    logic [7:0] din;
    bit         ack;
    bit         glitch;
    logic       exp_err;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [8:0] bits;
    logic stop_b, start_b;
    int inh, nd0, k;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b0};

    reset = 1'b0; wr_ps2 = 1'b0; din = 8'd0; dev_c = 1'b0; dev_d = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_c_oe", {31'd0, ps2c_oe}, 32'd0);
    check("rst_d_oe", {31'd0, ps2d_oe}, 32'd0);
    check("rst_done", {31'd0, tx_done_tick}, 32'd0);
    check("rst_err",  {31'd0, tx_err}, 32'd0);
    check("rst_idle", {31'd0, tx_idle}, 32'd1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].din, vecs[i].ack, vecs[i].glitch, vecs[i].exp_err);
      repeat (10) @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      bit a, g;
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      g = 1'($urandom_range(0, 1));
      run_xfer($sformatf("rnd%0d", i), d, a, g, ~a);
      repeat (10) @(negedge clk);
    end

    // Watchdog: device never clocks.
    nd0 = n_done;
    send(8'h3C);
    k = 1;
    while (!tx_done_tick && k < TMO + 100) begin @(negedge clk); k++; end
    check("timeout_cycles", k - 1, TMO);
    check("timeout_c_oe", {31'd0, ps2c_oe}, 32'd0);
    check("timeout_d_oe", {31'd0, ps2d_oe}, 32'd0);
    check("timeout_err", {31'd0, tx_err}, 32'd1);
    @(negedge clk);
    check("timeout_idle", {31'd0, tx_idle}, 32'd1);
    check("timeout_count", n_done - nd0, 32'd1);
    repeat (10) @(negedge clk);

    // Reset in the middle of the data phase.
    nd0 = n_done;
    send(8'hA5);
    device(5, 1'b1, 1'b0, bits, stop_b, inh, start_b);
    check("busy_before_rst", {31'd0, tx_idle}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_c_oe", {31'd0, ps2c_oe}, 32'd0);
    check("midrst_d_oe", {31'd0, ps2d_oe}, 32'd0);
    check("midrst_idle", {31'd0, tx_idle}, 32'd1);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_done", n_done - nd0, 32'd0);

    // Second transfer with stray writes while busy.
    nd0 = n_done;
    send(8'hF4);
    fork
      device(12, 1'b1, 1'b0, bits, stop_b, inh, start_b);
      begin
        repeat (10) @(negedge clk);
        wr_ps2 = 1'b1; din = 8'h11;
        @(negedge clk);
        wr_ps2 = 1'b0;
        repeat (200) @(negedge clk);
        wr_ps2 = 1'b1; din = 8'h00;
        @(negedge clk);
        wr_ps2 = 1'b0; din = 8'hF4;
      end
    join
    check("f4_inhibit", inh, INH);
    check("f4_frame", {23'd0, bits}, {23'd0, model_frame(8'hF4)});
    check("f4_stop", {31'd0, stop_b}, 32'd1);
    finish_xfer("f4", nd0, 1'b0);
    repeat (100) @(negedge clk);
    check("no_queued_c_oe", {31'd0, ps2c_oe}, 32'd0);
    check("no_queued_idle", {31'd0, tx_idle}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
